// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered sync/blank/RGB
// (one pixel behind X/Y), pixel-clock output and built-in test patterns.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned X_W      = 10,
  parameter int unsigned Y_W      = 10
) (
  input  logic           CLK50MHZ,
  input  logic           RST,
  input  logic           EN,
  input  logic [1:0]     PATTERN,
  input  logic [7:0]     PIX_R,
  input  logic [7:0]     PIX_G,
  input  logic [7:0]     PIX_B,
  output logic [X_W-1:0] X,
  output logic [Y_W-1:0] Y,
  output logic           PIX_REQ,
  output logic           LINE_START,
  output logic           FRAME_START,
  output logic           VGA_HS,
  output logic           VGA_VS,
  output logic           VGA_BLANK_N,
  output logic           VGA_CLK_OUT,
  output logic [7:0]     VGA_R,
  output logic [7:0]     VGA_G,
  output logic [7:0]     VGA_B
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned D_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [X_W-1:0] H_ACT_X  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_SS_X   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] H_SE_X   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_W-1:0] H_LAST_X = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] BAR_X    = X_W'(H_ACTIVE / 8);
  localparam logic [Y_W-1:0] V_ACT_Y  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_SS_Y   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] V_SE_Y   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [Y_W-1:0] V_LAST_Y = Y_W'(V_TOTAL - 1);
  localparam logic [D_W-1:0] DIV_LAST = D_W'(CLK_DIV - 1);
  localparam logic [D_W-1:0] DIV_HALF = D_W'(CLK_DIV / 2);

  logic [D_W-1:0] div_q, div_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           blank_n_q, blank_n_d;
  logic [23:0]    rgb_q, rgb_d;

  logic           tick;
  logic           active;
  logic           h_sync_act;
  logic           v_sync_act;
  logic [2:0]     bar;
  logic [23:0]    pat_rgb;

  assign tick       = EN && (div_q == DIV_LAST);
  assign active     = (x_q < H_ACT_X) && (y_q < V_ACT_Y);
  assign h_sync_act = (x_q >= H_SS_X) && (x_q < H_SE_X);
  assign v_sync_act = (y_q >= V_SS_Y) && (y_q < V_SE_Y);

  always_comb begin
    bar = 3'(x_q / BAR_X);
    case (PATTERN)
      2'd0:    pat_rgb = {PIX_R, PIX_G, PIX_B};
      2'd1:    pat_rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      2'd2:    pat_rgb = (x_q[5] ^ y_q[5]) ? '1 : '0;
      default: pat_rgb = '1;
    endcase
  end

  always_comb begin
    div_d     = div_q;
    x_d       = x_q;
    y_d       = y_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    if (!EN) begin
      div_d     = '0;
      x_d       = '0;
      y_d       = '0;
      hs_d      = ~HS_POL;
      vs_d      = ~VS_POL;
      blank_n_d = 1'b0;
      rgb_d     = '0;
    end else begin
      div_d = tick ? '0 : div_q + D_W'(1);
      if (tick) begin
        if (x_q == H_LAST_X) begin
          x_d = '0;
          y_d = (y_q == V_LAST_Y) ? '0 : y_q + Y_W'(1);
        end else begin
          x_d = x_q + X_W'(1);
        end
        // Video path samples the pre-increment position so it stays aligned with sync.
        hs_d      = h_sync_act ? HS_POL : ~HS_POL;
        vs_d      = v_sync_act ? VS_POL : ~VS_POL;
        blank_n_d = active;
        rgb_d     = active ? pat_rgb : '0;
      end
    end
  end

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      div_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      div_q     <= div_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign X           = x_q;
  assign Y           = y_q;
  // Gated by RST so the request is low while reset holds the counters at (0,0).
  assign PIX_REQ     = EN && !RST && active;
  assign LINE_START  = tick && (x_q == '0);
  assign FRAME_START = tick && (x_q == '0) && (y_q == '0);
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_CLK_OUT = (div_q >= DIV_HALF);
  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a tiny 16x8 mode against a counter
// reference, plus the default 800x525 mode for sync widths and test patterns.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Small-mode instance signals
  logic       s_en;
  logic [1:0] s_pat;
  logic [7:0] s_pr, s_pg, s_pb;
  logic [9:0] s_x, s_y;
  logic       s_req, s_ls, s_fs, s_hs, s_vs, s_bn, s_ck;
  logic [7:0] s_r, s_g, s_b;

  // Default-mode instance signals
  logic       d_en;
  logic [1:0] d_pat;
  logic [23:0] d_pix;
  logic [9:0] d_x, d_y;
  logic       d_req, d_ls, d_fs, d_hs, d_vs, d_bn, d_ck;
  logic [7:0] d_r, d_g, d_b;

  logic [50:0] s_obs, d_obs;
  assign s_obs = {s_x, s_y, s_req, s_ls, s_fs, s_hs, s_vs, s_bn, s_ck, s_r, s_g, s_b};
  assign d_obs = {d_x, d_y, d_req, d_ls, d_fs, d_hs, d_vs, d_bn, d_ck, d_r, d_g, d_b};

  localparam logic [50:0] IDLE = {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'd0};

  int n_checks = 0;
  int n_pass   = 0;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .CLK_DIV(2), .X_W(10), .Y_W(10)
  ) u_small (
    .CLK50MHZ(clk), .RST(rst), .EN(s_en), .PATTERN(s_pat),
    .PIX_R(s_pr), .PIX_G(s_pg), .PIX_B(s_pb),
    .X(s_x), .Y(s_y), .PIX_REQ(s_req), .LINE_START(s_ls), .FRAME_START(s_fs),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bn), .VGA_CLK_OUT(s_ck),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
  );

  vga_timing_gen u_def (
    .CLK50MHZ(clk), .RST(rst), .EN(d_en), .PATTERN(d_pat),
    .PIX_R(d_pix[23:16]), .PIX_G(d_pix[15:8]), .PIX_B(d_pix[7:0]),
    .X(d_x), .Y(d_y), .PIX_REQ(d_req), .LINE_START(d_ls), .FRAME_START(d_fs),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bn), .VGA_CLK_OUT(d_ck),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b)
  );

  // Expected small-mode outputs k samples after (re)start: 16 px/line, 8 lines,
  // 2 clocks per pixel; registered outputs show the previous pixel.
  function automatic logic [50:0] small_exp(input int k);
    int n, x, y, q, qx, qy;
    logic req, ls, fs, hs, vs, bn, ck;
    logic [23:0] rgb;
    n   = k / 2;
    x   = n % 16;
    y   = (n / 16) % 8;
    req = (x < 8) && (y < 4);
    ck  = (k % 2) == 1;
    ls  = ck && (x == 0);
    fs  = ls && (y == 0);
    if (n == 0) begin
      hs = 1'b1; vs = 1'b1; bn = 1'b0; rgb = 24'h0;
    end else begin
      q   = n - 1;
      qx  = q % 16;
      qy  = (q / 16) % 8;
      bn  = (qx < 8) && (qy < 4);
      hs  = !((qx >= 10) && (qx < 13));
      vs  = !((qy >= 5) && (qy < 7));
      rgb = bn ? {8'(qx), 8'(qy), 8'h5A} : 24'h0;
    end
    return {10'(x), 10'(y), req, ls, fs, hs, vs, bn, ck, rgb};
  endfunction

  task automatic small_restart();
    s_en = 1'b0;
    @(negedge clk);
    s_en = 1'b1;
    s_pat = 2'd0;
    s_pr = 8'h00;
    s_pg = 8'h00;
    s_pb = 8'h5A;
  endtask

  // Advance one clock and present the external pixel for the current position.
  task automatic small_step(input int k);
    @(negedge clk);
    s_pr = 8'((k / 2) % 16);
    s_pg = 8'(((k / 2) / 16) % 8);
  endtask

  task automatic def_restart(input logic [1:0] pat, input logic [23:0] pix);
    d_en = 1'b0;
    @(negedge clk);
    d_en  = 1'b1;
    d_pat = pat;
    d_pix = pix;
  endtask

  task automatic test_reset();
    n_checks++;
    if (s_obs !== IDLE) $display("FAIL reset_small got %h want %h", s_obs, IDLE);
    else n_pass++;
    n_checks++;
    if (d_obs !== IDLE) $display("FAIL reset_default got %h want %h", d_obs, IDLE);
    else n_pass++;
  endtask

  task automatic test_small_frame();
    int hs_low, vs_low, ls_cnt, fs_cnt;
    logic [50:0] e;
    hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
    small_restart();
    for (int k = 1; k <= 300; k++) begin
      small_step(k);
      e = small_exp(k);
      n_checks++;
      if (s_obs !== e) $display("FAIL small_frame k=%0d got %h want %h", k, s_obs, e);
      else n_pass++;
      if (k <= 256) begin
        if (!s_hs) hs_low++;
        if (!s_vs) vs_low++;
        if (s_ls) ls_cnt++;
        if (s_fs) fs_cnt++;
      end
      if (k == 257) begin
        n_checks++;
        if (s_fs !== 1'b1) $display("FAIL small_frame_period got %b want 1", s_fs);
        else n_pass++;
      end
    end
    n_checks++;
    if (hs_low != 48) $display("FAIL small_hs_low got %0d want 48", hs_low);
    else n_pass++;
    n_checks++;
    if (vs_low != 64) $display("FAIL small_vs_low got %0d want 64", vs_low);
    else n_pass++;
    n_checks++;
    if (ls_cnt != 8) $display("FAIL small_line_starts got %0d want 8", ls_cnt);
    else n_pass++;
    n_checks++;
    if (fs_cnt != 1) $display("FAIL small_frame_starts got %0d want 1", fs_cnt);
    else n_pass++;
  endtask

  task automatic test_default_timing();
    int hs_f1, hs_f2, hs_r1, bn_r, bn_f, vs_low;
    logic hs_p, bn_p;
    hs_f1 = -1; hs_f2 = -1; hs_r1 = -1; bn_r = -1; bn_f = -1; vs_low = 0;
    hs_p = 1'b1; bn_p = 1'b0;
    def_restart(2'd0, 24'hA5C3E1);
    for (int k = 1; k <= 3400; k++) begin
      @(negedge clk);
      if (k == 2) begin
        n_checks++;
        if ({d_r, d_g, d_b} !== 24'hA5C3E1) $display("FAIL ext_pixel got %h want a5c3e1", {d_r, d_g, d_b});
        else n_pass++;
      end
      if (k == 1282) begin
        n_checks++;
        if ({d_r, d_g, d_b} !== 24'h0) $display("FAIL ext_porch_black got %h want 000000", {d_r, d_g, d_b});
        else n_pass++;
      end
      if (hs_p && !d_hs) begin
        if (hs_f1 < 0) hs_f1 = k;
        else if (hs_f2 < 0) hs_f2 = k;
      end
      if (!hs_p && d_hs && hs_r1 < 0) hs_r1 = k;
      if (!bn_p && d_bn && bn_r < 0) bn_r = k;
      if (bn_p && !d_bn && bn_f < 0) bn_f = k;
      if (!d_vs) vs_low++;
      hs_p = d_hs;
      bn_p = d_bn;
    end
    n_checks++;
    if (hs_f2 - hs_f1 != 1600) $display("FAIL hs_period got %0d want 1600", hs_f2 - hs_f1);
    else n_pass++;
    n_checks++;
    if (hs_r1 - hs_f1 != 192) $display("FAIL hs_low got %0d want 192", hs_r1 - hs_f1);
    else n_pass++;
    n_checks++;
    if (bn_r != 2) $display("FAIL blank_first_rise got %0d want 2", bn_r);
    else n_pass++;
    n_checks++;
    if (bn_f - bn_r != 1280) $display("FAIL blank_high got %0d want 1280", bn_f - bn_r);
    else n_pass++;
    n_checks++;
    if (vs_low != 0) $display("FAIL vs_early_lines got %0d want 0", vs_low);
    else n_pass++;
  endtask

  task automatic test_colour_bars();
    logic [23:0] want;
    logic        chk;
    def_restart(2'd1, 24'h123456);
    for (int k = 1; k <= 1282; k++) begin
      @(negedge clk);
      chk = 1'b1;
      case (k)
        2:       want = 24'h000000;
        160:     want = 24'h000000;
        162:     want = 24'h0000FF;
        322:     want = 24'h00FF00;
        1122:    want = 24'hFFFFFF;
        1280:    want = 24'hFFFFFF;
        1282:    want = 24'h000000;
        default: begin chk = 1'b0; want = 24'h0; end
      endcase
      if (chk) begin
        n_checks++;
        if ({d_r, d_g, d_b} !== want) $display("FAIL colour_bars k=%0d got %h want %h", k, {d_r, d_g, d_b}, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_checkerboard();
    logic [23:0] want;
    logic        chk;
    def_restart(2'd2, 24'h123456);
    for (int k = 1; k <= 51266; k++) begin
      @(negedge clk);
      chk = 1'b1;
      case (k)
        64:      want = 24'h000000;
        66:      want = 24'hFFFFFF;
        51202:   want = 24'hFFFFFF;
        51266:   want = 24'h000000;
        default: begin chk = 1'b0; want = 24'h0; end
      endcase
      if (chk) begin
        n_checks++;
        if ({d_r, d_g, d_b} !== want) $display("FAIL checkerboard k=%0d got %h want %h", k, {d_r, d_g, d_b}, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_solid_and_switch();
    def_restart(2'd3, 24'h000000);
    for (int k = 1; k <= 1402; k++) begin
      @(negedge clk);
      if (k == 2) begin
        n_checks++;
        if ({d_r, d_g, d_b} !== 24'hFFFFFF) $display("FAIL solid_white got %h want ffffff", {d_r, d_g, d_b});
        else n_pass++;
      end
      if (k == 3) begin
        d_pat = 2'd0;
        d_pix = 24'h112233;
      end
      if (k == 4) begin
        n_checks++;
        if ({d_r, d_g, d_b} !== 24'h112233) $display("FAIL pattern_switch got %h want 112233", {d_r, d_g, d_b});
        else n_pass++;
      end
      if (k == 1402) begin
        n_checks++;
        if ({d_r, d_g, d_b} !== 24'h0) $display("FAIL solid_porch got %h want 000000", {d_r, d_g, d_b});
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midline();
    small_restart();
    for (int k = 1; k <= 43; k++) small_step(k);
    n_checks++;
    if (s_obs !== small_exp(43)) $display("FAIL rst_pre got %h want %h", s_obs, small_exp(43));
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (s_obs !== IDLE) $display("FAIL rst_immediate got %h want %h", s_obs, IDLE);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (s_obs !== IDLE) $display("FAIL rst_held got %h want %h", s_obs, IDLE);
    else n_pass++;
    rst  = 1'b0;
    s_pr = 8'h00;
    s_pg = 8'h00;
    #1;
    n_checks++;
    if (s_fs !== 1'b0) $display("FAIL rst_release_fs_early got %b want 0", s_fs);
    else n_pass++;
    // FRAME_START belongs to the second clock cycle after release.
    @(negedge clk);
    n_checks++;
    if (s_obs !== small_exp(1)) $display("FAIL rst_first_frame got %h want %h", s_obs, small_exp(1));
    else n_pass++;
  endtask

  task automatic test_en_drop();
    small_restart();
    for (int k = 1; k <= 75; k++) small_step(k);
    n_checks++;
    if ({s_x, s_y, s_req} !== {10'd5, 10'd2, 1'b1}) $display("FAIL en_pre got %h want %h", {s_x, s_y, s_req}, {10'd5, 10'd2, 1'b1});
    else n_pass++;
    #1 s_en = 1'b0;
    #1;
    n_checks++;
    if (s_req !== 1'b0) $display("FAIL en_drop_req got %b want 0", s_req);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (s_obs !== IDLE) $display("FAIL en_drop_idle got %h want %h", s_obs, IDLE);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (s_obs !== IDLE) $display("FAIL en_low_hold got %h want %h", s_obs, IDLE);
    else n_pass++;
    s_en = 1'b1;
    s_pr = 8'h00;
    s_pg = 8'h00;
    small_step(1);
    n_checks++;
    if (s_obs !== small_exp(1)) $display("FAIL en_rise_frame got %h want %h", s_obs, small_exp(1));
    else n_pass++;
    small_step(2);
    n_checks++;
    if (s_obs !== small_exp(2)) $display("FAIL en_rise_pixel0 got %h want %h", s_obs, small_exp(2));
    else n_pass++;
  endtask

  initial begin
    rst   = 1'b1;
    s_en  = 1'b1;
    s_pat = 2'd0;
    s_pr  = 8'h00;
    s_pg  = 8'h00;
    s_pb  = 8'h5A;
    d_en  = 1'b1;
    d_pat = 2'd0;
    d_pix = 24'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_small_frame();
    test_default_timing();
    test_colour_bars();
    test_checkerboard();
    test_solid_and_switch();
    test_reset_midline();
    test_en_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
